// File: rtl/sign_mag_accum_pkg.sv
// Shared encodings for the sign-magnitude accumulator: operation codes and
// the control FSM states.
package sign_mag_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_LOAD = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/sign_mag_accum_if.sv
// Operand/result handshake bundle for the sign-magnitude accumulator.
// master: the operand source / result consumer side. slave: the accumulator.
interface sign_mag_accum_if #(
  parameter int N = 8
) ();

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [1:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] acc;
  logic         ovf;
  logic         ovf_sticky;

  modport master (
    output in_valid, in_data, op, out_ready,
    input  in_ready, out_valid, acc, ovf, ovf_sticky
  );

  modport slave (
    input  in_valid, in_data, op, out_ready,
    output in_ready, out_valid, acc, ovf, ovf_sticky
  );

endinterface

// File: rtl/sign_mag_accum_core.sv
// Combinational arithmetic for the accumulator, split in two halves so the
// top level can register between them:
//   sort half  - effective signs, max/min magnitude, result sign, add-or-subtract
//   arith half - magnitude add/sub, overflow, saturate/wrap, -0 normalisation
module sign_mag_core
  import sign_mag_pkg::*;
#(
  parameter int N   = 8,
  parameter bit SAT = 1'b1
) (
  // sort inputs: current accumulator, operand, operation
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  op_e          op,
  output logic [N-2:0] sort_max,
  output logic [N-2:0] sort_min,
  output logic         sort_sign,
  output logic         sort_sub,
  // arith inputs: registered copies of the sort outputs
  input  logic [N-2:0] max_mag,
  input  logic [N-2:0] min_mag,
  input  logic         res_sign,
  input  logic         is_sub,
  output logic [N-1:0] result,
  output logic         ovf
);

  localparam int M = N - 1;

  logic [M-1:0] a_mag;
  logic [M-1:0] b_mag;
  logic         a_sign;
  logic         b_sign;
  logic         a_ge_b;
  logic [M:0]   sum;
  logic [M-1:0] diff;
  logic [M-1:0] mag;

  assign a_mag = a[M-1:0];
  assign b_mag = b[M-1:0];

  // Sort operands by magnitude; a zero magnitude always counts as positive so
  // -0 operands behave exactly like +0.
  always_comb begin
    sort_max  = '0;
    sort_min  = '0;
    sort_sign = 1'b0;
    sort_sub  = 1'b0;
    a_sign    = a[M] & (a_mag != '0);
    b_sign    = ((op == OP_SUB) ? ~b[M] : b[M]) & (b_mag != '0);
    a_ge_b    = (a_mag >= b_mag);
    case (op)
      OP_ADD, OP_SUB: begin
        sort_max  = a_ge_b ? a_mag : b_mag;
        sort_min  = a_ge_b ? b_mag : a_mag;
        sort_sign = a_ge_b ? a_sign : b_sign;
        sort_sub  = (a_sign != b_sign);
      end
      // LOAD reuses the add path with a zero second term; it can never carry.
      OP_LOAD: begin
        sort_max  = b_mag;
        sort_sign = b[M];
      end
      default: begin
        sort_max = '0;
      end
    endcase
  end

  // Magnitude add/subtract, overflow handling and -0 clean-up. Equal
  // magnitudes with differing signs give a zero difference, which the final
  // sign gating turns into +0.
  always_comb begin
    sum  = {1'b0, max_mag} + {1'b0, min_mag};
    diff = max_mag - min_mag;
    mag  = '0;
    ovf  = 1'b0;
    if (is_sub) begin
      mag = diff;
    end else if (sum[M]) begin
      ovf = 1'b1;
      if (SAT) begin
        mag = '1;
      end else begin
        mag = sum[M-1:0];
      end
    end else begin
      mag = sum[M-1:0];
    end
    result = {res_sign & (mag != '0), mag};
  end

endmodule

// File: rtl/sign_mag_accum.sv
// Streaming sign-magnitude accumulator. One operation in flight at a time:
// accept in IDLE, sort in CALC, write acc/ovf and raise out_valid two edges
// after the accept, then hold the result in DONE until out_ready.
module sign_mag_accum
  import sign_mag_pkg::*;
#(
  parameter int N   = 8,
  parameter bit SAT = 1'b1
) (
  input logic             clk,
  input logic             reset,
  sign_mag_accum_if.slave bus
);

  localparam int M = N - 1;

  state_e       state_reg;
  state_e       state_next;
  logic [N-1:0] data_reg;
  op_e          op_reg;
  logic [M-1:0] max_reg;
  logic [M-1:0] min_reg;
  logic         sign_reg;
  logic         sub_reg;
  logic [N-1:0] acc_reg;
  logic         ovf_reg;
  logic         sticky_reg;
  logic         out_valid_reg;

  logic         accept;
  logic [M-1:0] sort_max;
  logic [M-1:0] sort_min;
  logic         sort_sign;
  logic         sort_sub;
  logic [N-1:0] core_result;
  logic         core_ovf;

  assign accept = bus.in_valid && (state_reg == ST_IDLE);

  sign_mag_core #(
    .N   (N),
    .SAT (SAT)
  ) u_core (
    .a         (acc_reg),
    .b         (data_reg),
    .op        (op_reg),
    .sort_max  (sort_max),
    .sort_min  (sort_min),
    .sort_sign (sort_sign),
    .sort_sub  (sort_sub),
    .max_mag   (max_reg),
    .min_mag   (min_reg),
    .res_sign  (sign_reg),
    .is_sub    (sub_reg),
    .result    (core_result),
    .ovf       (core_ovf)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. DONE spends its first cycle writing the result, so it
  // only releases once out_valid is actually up and the consumer takes it.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (bus.in_valid) state_next = ST_CALC;
      ST_CALC: state_next = ST_DONE;
      ST_DONE: if (out_valid_reg && bus.out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Capture operand and operation on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= '0;
      op_reg   <= OP_ADD;
    end else if (accept) begin
      data_reg <= bus.in_data;
      op_reg   <= op_e'(bus.op);
    end
  end

  // CALC stage registers: sorted magnitudes, result sign, effective op.
  always_ff @(posedge clk) begin
    if (reset) begin
      max_reg  <= '0;
      min_reg  <= '0;
      sign_reg <= 1'b0;
      sub_reg  <= 1'b0;
    end else if (state_reg == ST_CALC) begin
      max_reg  <= sort_max;
      min_reg  <= sort_min;
      sign_reg <= sort_sign;
      sub_reg  <= sort_sub;
    end
  end

  // Result write on DONE entry, then hold until the consumer takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      sticky_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if ((state_reg == ST_DONE) && !out_valid_reg) begin
      acc_reg       <= core_result;
      ovf_reg       <= core_ovf;
      out_valid_reg <= 1'b1;
      if (op_reg == OP_CLR) begin
        sticky_reg <= 1'b0;
      end else if ((op_reg == OP_ADD) || (op_reg == OP_SUB)) begin
        sticky_reg <= sticky_reg | core_ovf;
      end
    end else if ((state_reg == ST_DONE) && bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.in_ready   = (state_reg == ST_IDLE);
  assign bus.out_valid  = out_valid_reg;
  assign bus.acc        = acc_reg;
  assign bus.ovf        = ovf_reg;
  assign bus.ovf_sticky = sticky_reg;

endmodule

// File: tb/tb_sign_mag_accum.sv
// Directed bench: a saturating and a wrapping accumulator driven in lockstep
// from the same stimulus, each result compared against hand-computed values.
module tb_sign_mag_accum;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] op;
  logic       out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  sign_mag_accum_if #(.N(8)) if_sat  ();
  sign_mag_accum_if #(.N(8)) if_wrap ();

  assign if_sat.in_valid   = in_valid;
  assign if_sat.in_data    = in_data;
  assign if_sat.op         = op;
  assign if_sat.out_ready  = out_ready;
  assign if_wrap.in_valid  = in_valid;
  assign if_wrap.in_data   = in_data;
  assign if_wrap.op        = op;
  assign if_wrap.out_ready = out_ready;

  sign_mag_accum #(.N(8), .SAT(1'b1)) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (if_sat.slave)
  );

  sign_mag_accum #(.N(8), .SAT(1'b0)) u_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (if_wrap.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction with out_ready held high: checks the latency
  // (out_valid exactly two edges after accept) and the result on both DUTs.
  task automatic run_op(input string name, input logic [1:0] o, input logic [7:0] d,
                        input logic [7:0] s_acc, input logic s_ovf, input logic s_st,
                        input logic [7:0] w_acc, input logic w_ovf, input logic w_st);
    @(negedge clk);
    chk({name, ".in_ready_idle"}, 16'(if_sat.in_ready), 16'd1);
    in_valid  = 1'b1;
    in_data   = d;
    op        = o;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({name, ".busy_e0"}, 16'(if_sat.in_ready), 16'd0);
    chk({name, ".nvalid_e0"}, 16'(if_sat.out_valid), 16'd0);
    @(posedge clk); #1;
    chk({name, ".nvalid_e1"}, 16'(if_sat.out_valid), 16'd0);
    @(posedge clk); #1;
    chk({name, ".sat.valid"}, 16'(if_sat.out_valid), 16'd1);
    chk({name, ".sat.acc"}, 16'(if_sat.acc), 16'(s_acc));
    chk({name, ".sat.ovf"}, 16'(if_sat.ovf), 16'(s_ovf));
    chk({name, ".sat.sticky"}, 16'(if_sat.ovf_sticky), 16'(s_st));
    chk({name, ".wrap.valid"}, 16'(if_wrap.out_valid), 16'd1);
    chk({name, ".wrap.acc"}, 16'(if_wrap.acc), 16'(w_acc));
    chk({name, ".wrap.ovf"}, 16'(if_wrap.ovf), 16'(w_ovf));
    chk({name, ".wrap.sticky"}, 16'(if_wrap.ovf_sticky), 16'(w_st));
    @(posedge clk); #1;
    chk({name, ".idle_after"}, 16'(if_sat.in_ready), 16'd1);
    chk({name, ".nvalid_after"}, 16'(if_sat.out_valid), 16'd0);
    $display("txn %s op=%0d data=%02h -> sat acc=%02h ovf=%0d st=%0d | wrap acc=%02h ovf=%0d st=%0d",
             name, o, d, if_sat.acc, if_sat.ovf, if_sat.ovf_sticky,
             if_wrap.acc, if_wrap.ovf, if_wrap.ovf_sticky);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    op        = 2'b00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.acc", 16'(if_sat.acc), 16'h00);
    chk("rst.ovf", 16'(if_sat.ovf), 16'd0);
    chk("rst.sticky", 16'(if_sat.ovf_sticky), 16'd0);
    chk("rst.valid", 16'(if_sat.out_valid), 16'd0);
    chk("rst.in_ready", 16'(if_sat.in_ready), 16'd1);
    chk("rst.wrap.acc", 16'(if_wrap.acc), 16'h00);
    @(negedge clk);
    reset = 1'b0;

    // 1: basic add with mixed signs: 5 + (-3) = 2
    run_op("t1.load", 2'b10, 8'h05, 8'h05, 0, 0, 8'h05, 0, 0);
    run_op("t1.add",  2'b00, 8'h83, 8'h02, 0, 0, 8'h02, 0, 0);

    // 2: 100 + 50 overflows: saturate to 127, wrap to 150-128 = 22
    run_op("t2.load", 2'b10, 8'h64, 8'h64, 0, 0, 8'h64, 0, 0);
    run_op("t2.add",  2'b00, 8'h32, 8'h7F, 1, 1, 8'h16, 1, 1);
    // CLEAR drops the sticky flag
    run_op("t4.clr",  2'b11, 8'h5A, 8'h00, 0, 0, 8'h00, 0, 0);

    // 3: zero results and -0 handling
    run_op("t3.load5", 2'b10, 8'h05, 8'h05, 0, 0, 8'h05, 0, 0);
    run_op("t3.sub5",  2'b01, 8'h05, 8'h00, 0, 0, 8'h00, 0, 0);
    run_op("t3.ldm0",  2'b10, 8'h80, 8'h00, 0, 0, 8'h00, 0, 0);
    run_op("t3.load5b", 2'b10, 8'h05, 8'h05, 0, 0, 8'h05, 0, 0);
    run_op("t3.addm5", 2'b00, 8'h85, 8'h00, 0, 0, 8'h00, 0, 0);

    // 4: -20 - (-30) = +10
    run_op("t4.load", 2'b10, 8'h94, 8'h94, 0, 0, 8'h94, 0, 0);
    run_op("t4.sub",  2'b01, 8'h9E, 8'h0A, 0, 0, 8'h0A, 0, 0);

    // negative overflow: -127 - 1; wrap leaves magnitude 0, so sign drops to +
    run_op("neg.load", 2'b10, 8'hFF, 8'hFF, 0, 0, 8'hFF, 0, 0);
    run_op("neg.sub",  2'b01, 8'h01, 8'hFF, 1, 1, 8'h00, 1, 1);
    // LOAD clears ovf but leaves sticky alone
    run_op("neg.load3", 2'b10, 8'h03, 8'h03, 0, 1, 8'h03, 0, 1);
    run_op("t5.clr", 2'b11, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0);

    // 5: consumer stalls 5 cycles; a pending ADD must wait until release
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 8'h10;
    op        = 2'b10;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_data = 8'h01;
    op      = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("t5.hold.valid", 16'(if_sat.out_valid), 16'd1);
      chk("t5.hold.acc", 16'(if_sat.acc), 16'h10);
      chk("t5.hold.in_ready", 16'(if_sat.in_ready), 16'd0);
      $display("txn t5.hold cycle=%0d acc=%02h valid=%0d in_ready=%0d",
               i, if_sat.acc, if_sat.out_valid, if_sat.in_ready);
      @(posedge clk); #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5.release.valid", 16'(if_sat.out_valid), 16'd0);
    chk("t5.release.in_ready", 16'(if_sat.in_ready), 16'd1);
    chk("t5.release.acc", 16'(if_sat.acc), 16'h10);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t5.accept2.busy", 16'(if_sat.in_ready), 16'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("t5.add.valid", 16'(if_sat.out_valid), 16'd1);
    chk("t5.add.acc", 16'(if_sat.acc), 16'h11);
    chk("t5.add.wrap.acc", 16'(if_wrap.acc), 16'h11);
    $display("txn t5.add acc=%02h valid=%0d", if_sat.acc, if_sat.out_valid);
    repeat (3) begin
      @(posedge clk); #1;
      chk("t5.single.valid", 16'(if_sat.out_valid), 16'd0);
      chk("t5.single.acc", 16'(if_sat.acc), 16'h11);
    end

    // 6: reset during CALC discards the in-flight LOAD
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h22;
    op       = 2'b10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t6.calc.busy", 16'(if_sat.in_ready), 16'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t6.rst.valid", 16'(if_sat.out_valid), 16'd0);
    chk("t6.rst.acc", 16'(if_sat.acc), 16'h00);
    chk("t6.rst.in_ready", 16'(if_sat.in_ready), 16'd1);
    chk("t6.rst.wrap.acc", 16'(if_wrap.acc), 16'h00);
    $display("txn t6.reset acc=%02h valid=%0d in_ready=%0d",
             if_sat.acc, if_sat.out_valid, if_sat.in_ready);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t6.after.valid", 16'(if_sat.out_valid), 16'd0);
      chk("t6.after.acc", 16'(if_sat.acc), 16'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
